// File: rtl/stopwatch_display_if.sv
`default_nettype none
// ============================================================================
// stopwatch_display_if : count input, BCD result and display lines
// Rev 1.0
// ============================================================================
interface stopwatch_display_if;
  logic [13:0] count;
  logic [15:0] bcd;
  logic        busy;
  logic        done;
  logic        err;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (output count, input bcd, busy, done, err, an, seg, dp);
  modport slave  (input count, output bcd, busy, done, err, an, seg, dp);
endinterface
`default_nettype wire

// File: rtl/stopwatch_display.sv
`default_nettype none
// ============================================================================
// stopwatch_display : double-dabble binary->BCD plus 4-digit 7-seg multiplexer
// Optional macro STOPWATCH_BLANK_EN blanks a leading zero in digit 3.
// Rev 1.0
// ============================================================================
module stopwatch_display #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic               clk,
  input  logic               rst,
  stopwatch_display_if.slave bus
);

  localparam int          CW        = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] REF_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [13:0] MAX_COUNT = 14'd9999;
  localparam logic [3:0]  LAST_ITER = 4'd13;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic          busy;
  logic [13:0]   last;
  logic [29:0]   sh;
  logic [29:0]   adj;
  logic [3:0]    iter;
  logic [15:0]   bcd_q;
  logic          done_q;
  logic          err_q;
  logic [CW-1:0] ref_cnt;
  logic [1:0]    index;
  logic [3:0]    an_q;
  logic [6:0]    seg_q;
  logic [6:0]    seg_next;
  logic          dp_q;
  logic [3:0]    nibble;

  // ---------------- converter FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (bus.count != last && bus.count <= MAX_COUNT) state_next = S_SHIFT;
      S_SHIFT: if (iter == LAST_ITER) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_SHIFT) || (state == S_DONE);
  end

  // Add-3 correction on each BCD nibble before the shift
  always_comb begin
    adj = sh;
    for (int k = 0; k < 4; k++) begin
      if (sh[14+4*k +: 4] >= 4'd5) adj[14+4*k +: 4] = sh[14+4*k +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last   <= 14'd0;
      sh     <= 30'd0;
      iter   <= 4'd0;
      bcd_q  <= 16'd0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.count != last) begin
            last <= bus.count;
            sh   <= {16'd0, bus.count};
            iter <= 4'd0;
            if (bus.count > MAX_COUNT) err_q <= 1'b1;
          end
        end
        S_SHIFT: begin
          sh   <= {adj[28:0], 1'b0};
          iter <= iter + 4'd1;
        end
        S_DONE: begin
          bcd_q  <= sh[29:14];
          done_q <= 1'b1;
          err_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // ---------------- display multiplexer ----------------
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = 7'h7F;
    endcase
  endfunction

  always_comb begin
    case (index)
      2'd0:    nibble = bcd_q[3:0];
      2'd1:    nibble = bcd_q[7:4];
      2'd2:    nibble = bcd_q[11:8];
      default: nibble = bcd_q[15:12];
    endcase
    if (err_q) begin
      seg_next = 7'h3F;
    end else begin
      seg_next = seg_decode(nibble);
`ifdef STOPWATCH_BLANK_EN
      if (index == 2'd3 && nibble == 4'd0) seg_next = 7'h7F;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_cnt <= '0;
      index   <= 2'd0;
      an_q    <= 4'hF;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
    end else begin
      if (ref_cnt == REF_MAX) begin
        ref_cnt <= '0;
        index   <= index + 2'd1;
      end else begin
        ref_cnt <= ref_cnt + 1'b1;
      end
      an_q  <= ~(4'b0001 << index);
      seg_q <= seg_next;
      dp_q  <= (index != 2'd2);
    end
  end

  assign bus.bcd  = bcd_q;
  assign bus.busy = busy;
  assign bus.done = done_q;
  assign bus.err  = err_q;
  assign bus.an   = an_q;
  assign bus.seg  = seg_q;
  assign bus.dp   = dp_q;

endmodule
`default_nettype wire
